// File: rtl/mem_seq_ctrl_pkg.sv
// Shared definitions for the scratch-memory command sequencer: widths,
// opcodes, FSM encoding and small opcode/address helpers.
package mem_seq_ctrl_pkg;

  // Defaults shared with the 6-nibble scratch memory block.
  localparam int DATA_W = 4;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 6;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LD   = 3'd1,
    OP_ST   = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4,
    OP_SETP = 3'd5,
    OP_LDI  = 3'd6,
    OP_STI  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WBACK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Only the first DEPTH locations exist; everything above is an error.
  function automatic logic addrValid(input logic [ADDR_W-1:0] a);
    return (int'(a) < DEPTH);
  endfunction

  // Pointer-indexed ops take their address from PTR and bump it when done.
  function automatic logic usesPtr(input op_t op);
    return (op == OP_LDI) || (op == OP_STI);
  endfunction

  function automatic logic isStore(input op_t op);
    return (op == OP_ST) || (op == OP_STI);
  endfunction

  function automatic logic isRmw(input op_t op);
    return (op == OP_INC) || (op == OP_DEC);
  endfunction

endpackage

// File: rtl/mem_seq_ctrl_if.sv
// Command, result and memory-pin bundle of the sequencer.
//
// Handshake: a command transfers on a rising CLK edge where CMD_VALID and
// CMD_READY are both 1. CMD_READY never depends on CMD_VALID. Once accepted,
// the command's fields are latched and CMD_* is ignored until the controller
// is back in IDLE. RES_VALID is a single-cycle pulse with no back-pressure.
//
// modport master: command source plus memory (drives CMD_* and MEM_DO).
// modport slave : the sequencer itself.
interface mem_seq_ctrl_if;
  import mem_seq_ctrl_pkg::*;

  logic              CMD_VALID;
  logic              CMD_READY;
  logic [2:0]        CMD_OP;
  logic [ADDR_W-1:0] CMD_ADR;
  logic [DATA_W-1:0] CMD_DATA;
  logic              RES_VALID;
  logic [DATA_W-1:0] RES_DATA;
  logic              RES_CARRY;
  logic              RES_ERR;
  logic [ADDR_W-1:0] PTR;
  logic [ADDR_W-1:0] MEM_ADR;
  logic [DATA_W-1:0] MEM_DI;
  logic [DATA_W-1:0] MEM_DO;
  logic              MEM_EN;
  logic              MEM_WR;

  modport master (
    output CMD_VALID, CMD_OP, CMD_ADR, CMD_DATA, MEM_DO,
    input  CMD_READY, RES_VALID, RES_DATA, RES_CARRY, RES_ERR, PTR,
           MEM_ADR, MEM_DI, MEM_EN, MEM_WR
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_ADR, CMD_DATA, MEM_DO,
    output CMD_READY, RES_VALID, RES_DATA, RES_CARRY, RES_ERR, PTR,
           MEM_ADR, MEM_DI, MEM_EN, MEM_WR
  );
endinterface

// File: rtl/mem_seq_ptr.sv
// Index pointer for LDI/STI: range-checked load and wrapping increment.
module mem_seq_ptr
  import mem_seq_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] loadVal,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr,
  output logic              loadOk
);

  // An out-of-range load value is refused and reported to the FSM.
  assign loadOk = addrValid(loadVal);

  // Pointer register: refused loads leave it untouched; increment wraps at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (load && loadOk) begin
      ptr <= loadVal;
    end else if (inc) begin
      ptr <= (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/mem_seq_ctrl.sv
// Command sequencer for the 6-nibble scratch memory. One command at a time:
// IDLE accepts, ACCESS does the single read or write, WBACK writes back the
// incremented/decremented nibble, DONE pulses the result.
module mem_seq_ctrl
  import mem_seq_ctrl_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  mem_seq_ctrl_if.slave bus,
  output state_t       dbgState
);

  state_t            state, stateNext;
  op_t               opR;
  logic [ADDR_W-1:0] adrR;
  logic [DATA_W-1:0] dataR;
  logic [DATA_W-1:0] resDataR;
  logic              carryR;
  logic              errR;

  logic              cmdReady;
  logic              accept;
  op_t               cmdOp;
  logic [ADDR_W-1:0] effAdr;
  logic [ADDR_W-1:0] ptr;
  logic              ptrLoad;
  logic              ptrInc;
  logic              ptrLoadOk;
  logic              memEn;
  logic              memWr;
  logic [ADDR_W-1:0] memAdr;
  logic [DATA_W-1:0] memDi;
  logic [DATA_W-1:0] wbVal;
  logic              wbCarry;
  logic              resValid;
  logic              resOut;

  assign cmdReady = (state == IDLE) && !RST;
  assign accept   = bus.CMD_VALID && cmdReady;
  assign cmdOp    = op_t'(bus.CMD_OP);
  assign effAdr   = usesPtr(cmdOp) ? ptr : bus.CMD_ADR;

  // resDataR holds the nibble captured in ACCESS while in WBACK.
  assign wbVal   = (opR == OP_INC) ? resDataR + DATA_W'(1) : resDataR - DATA_W'(1);
  assign wbCarry = (opR == OP_INC) ? (resDataR == '1) : (resDataR == '0);

  mem_seq_ptr uPtr (
    .clk     (CLK),
    .rst     (RST),
    .load    (ptrLoad),
    .loadVal (bus.CMD_ADR),
    .inc     (ptrInc),
    .ptr     (ptr),
    .loadOk  (ptrLoadOk)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= stateNext;
  end

  // Command latch and result registers; reset discards any command in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      opR      <= OP_NOP;
      adrR     <= '0;
      dataR    <= '0;
      resDataR <= '0;
      carryR   <= 1'b0;
      errR     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opR      <= cmdOp;
            adrR     <= effAdr;
            dataR    <= bus.CMD_DATA;
            resDataR <= '0;
            carryR   <= 1'b0;
            if (cmdOp == OP_SETP)     errR <= !ptrLoadOk;
            else if (cmdOp == OP_NOP) errR <= 1'b0;
            else                      errR <= !addrValid(effAdr);
          end
        end
        ACCESS: begin
          if (!isStore(opR)) resDataR <= bus.MEM_DO;
        end
        WBACK: begin
          resDataR <= wbVal;
          carryR   <= wbCarry;
        end
        default: ;
      endcase
    end
  end

  // Next-state and memory/pointer strobes.
  always_comb begin
    stateNext = state;
    memEn     = 1'b0;
    memWr     = 1'b0;
    memAdr    = '0;
    memDi     = '0;
    resValid  = 1'b0;
    ptrLoad   = 1'b0;
    ptrInc    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmdOp)
            OP_NOP:  stateNext = IDLE;
            OP_SETP: begin
              ptrLoad   = 1'b1;
              stateNext = DONE;
            end
            default: stateNext = addrValid(effAdr) ? ACCESS : DONE;
          endcase
        end
      end
      ACCESS: begin
        memEn  = 1'b1;
        memAdr = adrR;
        if (isStore(opR)) begin
          memWr     = 1'b1;
          memDi     = dataR;
          stateNext = DONE;
        end else if (isRmw(opR)) begin
          stateNext = WBACK;
        end else begin
          stateNext = DONE;
        end
      end
      WBACK: begin
        memEn     = 1'b1;
        memWr     = 1'b1;
        memAdr    = adrR;
        memDi     = wbVal;
        stateNext = DONE;
      end
      DONE: begin
        resValid  = 1'b1;
        ptrInc    = usesPtr(opR) && !errR;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Reset masks the memory pins and the result so an aborted command leaves no trace.
  assign resOut        = resValid && !RST;
  assign bus.CMD_READY = cmdReady;
  assign bus.MEM_EN    = memEn && !RST;
  assign bus.MEM_WR    = memWr && !RST;
  assign bus.MEM_ADR   = RST ? '0 : memAdr;
  assign bus.MEM_DI    = RST ? '0 : memDi;
  assign bus.RES_VALID = resOut;
  assign bus.RES_DATA  = resOut ? resDataR : '0;
  assign bus.RES_CARRY = resOut && carryR;
  assign bus.RES_ERR   = resOut && errR;
  assign bus.PTR       = ptr;
  assign dbgState      = state;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Directed bench for mem_seq_ctrl with a behavioural 8-entry memory model.
module tb_mem_seq_ctrl;
  import mem_seq_ctrl_pkg::*;

  // Clock and reset
  logic   CLK = 1'b0;
  logic   RST = 1'b1;
  logic   memInit = 1'b1;
  state_t dbgState;

  always #5 CLK = ~CLK;

  mem_seq_ctrl_if bus ();

  mem_seq_ctrl dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus),
    .dbgState (dbgState)
  );

  // Memory model and activity monitors
  logic [DATA_W-1:0] mem [0:7];
  int nTests = 0;
  int nFail = 0;
  int wrCount = 0;
  int enCount = 0;
  int resCount = 0;
  int idleBusErr = 0;

  assign bus.MEM_DO = bus.MEM_EN ? mem[bus.MEM_ADR] : '0;

  always @(posedge CLK) begin
    if (memInit) begin
      for (int i = 0; i < 8; i++) mem[i] <= 4'(i + 1);
    end else begin
      if (bus.MEM_EN) enCount++;
      if (bus.MEM_EN && bus.MEM_WR) begin
        mem[bus.MEM_ADR] <= bus.MEM_DI;
        wrCount++;
      end
      if (bus.RES_VALID) resCount++;
    end
  end

  always @(negedge CLK) begin
    if (!bus.MEM_EN && (bus.MEM_ADR != '0 || bus.MEM_DI != '0)) idleBusErr++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: issue one command from a negedge, then collect its result.
  task automatic do_cmd(input string tag, input logic [2:0] op,
                        input logic [ADDR_W-1:0] adr, input logic [DATA_W-1:0] data,
                        input int expLat, input int expEn, input int expWr,
                        input logic [DATA_W-1:0] expData, input logic expCarry,
                        input logic expErr);
    int lat;
    int en0;
    int wr0;
    logic [DATA_W-1:0] rData;
    logic rCarry;
    logic rErr;
    lat = 0;
    rData = '0;
    rCarry = 1'b0;
    rErr = 1'b0;
    en0 = enCount;
    wr0 = wrCount;
    check({tag, "_ready"}, 32'(bus.CMD_READY), 32'd1);
    bus.CMD_VALID = 1'b1;
    bus.CMD_OP    = op;
    bus.CMD_ADR   = adr;
    bus.CMD_DATA  = data;
    @(posedge CLK);
    #1;
    bus.CMD_VALID = 1'b0;
    bus.CMD_OP    = 3'($urandom_range(0, 7));
    bus.CMD_ADR   = 3'($urandom_range(0, 7));
    bus.CMD_DATA  = 4'($urandom_range(0, 15));
    for (int i = 1; i <= 6; i++) begin
      if (lat == 0) begin
        @(negedge CLK);
        if (bus.RES_VALID) begin
          lat    = i;
          rData  = bus.RES_DATA;
          rCarry = bus.RES_CARRY;
          rErr   = bus.RES_ERR;
        end
      end
    end
    check({tag, "_lat"},   32'(lat),    32'(expLat));
    check({tag, "_data"},  32'(rData),  32'(expData));
    check({tag, "_carry"}, 32'(rCarry), 32'(expCarry));
    check({tag, "_err"},   32'(rErr),   32'(expErr));
    check({tag, "_en"},    32'(enCount - en0), 32'(expEn));
    check({tag, "_wr"},    32'(wrCount - wr0), 32'(expWr));
    @(negedge CLK);
  endtask

  // Directed sequence
  int resCount0;

  initial begin
    bus.CMD_VALID = 1'b0;
    bus.CMD_OP    = '0;
    bus.CMD_ADR   = '0;
    bus.CMD_DATA  = '0;
    repeat (3) @(negedge CLK);
    check("rst_ready", 32'(bus.CMD_READY), 32'd0);
    check("rst_en",    32'(bus.MEM_EN),    32'd0);
    check("rst_res",   32'(bus.RES_VALID), 32'd0);
    check("rst_ptr",   32'(bus.PTR),       32'd0);
    check("rst_state", 32'(dbgState),      32'(IDLE));
    RST = 1'b0;
    memInit = 1'b0;
    #1;
    check("rel_ready", 32'(bus.CMD_READY), 32'd1);
    @(negedge CLK);

    // Direct store/load and read-modify-write
    do_cmd("st2",  OP_ST,  3'd2, 4'hA, 2, 1, 1, 4'h0, 1'b0, 1'b0);
    check("mem2_a", 32'(mem[2]), 32'hA);
    do_cmd("ld2",  OP_LD,  3'd2, 4'h0, 2, 1, 0, 4'hA, 1'b0, 1'b0);
    do_cmd("st4",  OP_ST,  3'd4, 4'hF, 2, 1, 1, 4'h0, 1'b0, 1'b0);
    do_cmd("inc4", OP_INC, 3'd4, 4'h0, 3, 2, 1, 4'h0, 1'b1, 1'b0);
    check("mem4_0", 32'(mem[4]), 32'h0);
    do_cmd("ld4",  OP_LD,  3'd4, 4'h0, 2, 1, 0, 4'h0, 1'b0, 1'b0);
    do_cmd("st0",  OP_ST,  3'd0, 4'h0, 2, 1, 1, 4'h0, 1'b0, 1'b0);
    do_cmd("dec0", OP_DEC, 3'd0, 4'h0, 3, 2, 1, 4'hF, 1'b1, 1'b0);
    check("mem0_f", 32'(mem[0]), 32'hF);
    do_cmd("inc2", OP_INC, 3'd2, 4'h0, 3, 2, 1, 4'hB, 1'b0, 1'b0);
    do_cmd("dec2", OP_DEC, 3'd2, 4'h0, 3, 2, 1, 4'hA, 1'b0, 1'b0);
    check("mem2_a2", 32'(mem[2]), 32'hA);

    // Pointer-indexed ops with wrap
    do_cmd("setp5", OP_SETP, 3'd5, 4'h0, 1, 0, 0, 4'h0, 1'b0, 1'b0);
    check("ptr5", 32'(bus.PTR), 32'd5);
    do_cmd("sti3", OP_STI, 3'd0, 4'h3, 2, 1, 1, 4'h0, 1'b0, 1'b0);
    check("mem5_3", 32'(mem[5]), 32'h3);
    check("ptr0", 32'(bus.PTR), 32'd0);
    do_cmd("sti7", OP_STI, 3'd6, 4'h7, 2, 1, 1, 4'h0, 1'b0, 1'b0);
    check("mem0_7", 32'(mem[0]), 32'h7);
    check("ptr1", 32'(bus.PTR), 32'd1);
    do_cmd("ld5",  OP_LD,  3'd5, 4'h0, 2, 1, 0, 4'h3, 1'b0, 1'b0);
    do_cmd("ld0",  OP_LD,  3'd0, 4'h0, 2, 1, 0, 4'h7, 1'b0, 1'b0);
    do_cmd("ldi1", OP_LDI, 3'd4, 4'h0, 2, 1, 0, 4'h2, 1'b0, 1'b0);
    check("ptr2", 32'(bus.PTR), 32'd2);

    // Invalid addresses and NOP
    do_cmd("ld6",   OP_LD,   3'd6, 4'h0, 1, 0, 0, 4'h0, 1'b0, 1'b1);
    do_cmd("setp7", OP_SETP, 3'd7, 4'h0, 1, 0, 0, 4'h0, 1'b0, 1'b1);
    check("ptr2_keep", 32'(bus.PTR), 32'd2);
    do_cmd("st7",   OP_ST,   3'd7, 4'h9, 1, 0, 0, 4'h0, 1'b0, 1'b1);
    do_cmd("nop",   OP_NOP,  3'd3, 4'h5, 0, 0, 0, 4'h0, 1'b0, 1'b0);
    check("ptr2_nop", 32'(bus.PTR), 32'd2);

    // Reset during WBACK of an INC on location 2 (holds 0xA)
    resCount0 = resCount;
    check("rinc_ready", 32'(bus.CMD_READY), 32'd1);
    bus.CMD_VALID = 1'b1;
    bus.CMD_OP    = OP_INC;
    bus.CMD_ADR   = 3'd2;
    bus.CMD_DATA  = 4'h0;
    @(posedge CLK);
    #1;
    bus.CMD_VALID = 1'b0;
    @(negedge CLK);
    check("rinc_access", 32'(dbgState), 32'(ACCESS));
    @(negedge CLK);
    check("rinc_wback", 32'(dbgState), 32'(WBACK));
    check("rinc_wr_pre", 32'(bus.MEM_WR), 32'd1);
    RST = 1'b1;
    #1;
    check("rinc_en_rst", 32'(bus.MEM_EN), 32'd0);
    check("rinc_wr_rst", 32'(bus.MEM_WR), 32'd0);
    check("rinc_rdy_rst", 32'(bus.CMD_READY), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("rinc_ready_post", 32'(bus.CMD_READY), 32'd1);
    check("rinc_ptr", 32'(bus.PTR), 32'd0);
    check("rinc_mem2", 32'(mem[2]), 32'hA);
    repeat (3) @(negedge CLK);
    check("rinc_nores", 32'(resCount - resCount0), 32'd0);
    check("rinc_state", 32'(dbgState), 32'(IDLE));
    do_cmd("ld2post", OP_LD, 3'd2, 4'h0, 2, 1, 0, 4'hA, 1'b0, 1'b0);

    check("idle_bus_zero", 32'(idleBusErr), 32'd0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/mem_seq_ctrl.md
Name: mem_seq_ctrl

Overview:
- Command sequencer directly upstream of the internal 6-nibble scratch memory; the only master of its ADR/DI/EN/WR pins; consumes its combinational DO.
- Accepts one command at a time from instruction decode over a valid/ready handshake: load, store, read-modify-write increment/decrement, and pointer-indexed load/store with auto-increment.
- Returns one result pulse per completed command.

Parameters:
- DATA_W, 4, nibble width; must match the memory data width.
- ADDR_W, 3, memory address width.
- DEPTH, 6, number of implemented locations; addresses >= DEPTH are invalid.

Ports:
- CLK  in  1  system clock; same clock as the memory.
- RST  in  1  synchronous active-high reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  controller can accept.
- CMD_OP  in  3  opcode: 0 NOP, 1 LD, 2 ST, 3 INC, 4 DEC, 5 SETP, 6 LDI, 7 STI.
- CMD_ADR  in  ADDR_W  direct address for LD/ST/INC/DEC; new pointer for SETP.
- CMD_DATA  in  DATA_W  store data for ST/STI.
- RES_VALID  out  1  one-cycle completion pulse.
- RES_DATA  out  DATA_W  read value (LD/LDI), new value (INC/DEC), else 0.
- RES_CARRY  out  1  INC overflow / DEC borrow.
- RES_ERR  out  1  invalid address.
- PTR  out  ADDR_W  current index pointer.
- MEM_ADR  out  ADDR_W  memory address.
- MEM_DI  out  DATA_W  memory write data.
- MEM_DO  in  DATA_W  memory read data (combinational, gated by MEM_EN).
- MEM_EN  out  1  memory enable.
- MEM_WR  out  1  memory write enable; a write occurs at the CLK edge when MEM_EN=1 and MEM_WR=1.

Behaviour:
- Reset values: state IDLE, PTR=0, all other outputs 0.
- CMD_READY=1 only in IDLE with RST=0.
- MEM_EN and MEM_WR are forced 0 while RST=1, so no write happens on a reset edge. Reset mid-command aborts it: no RES_VALID, no pointer change.
- FSM states: IDLE, ACCESS, WBACK, DONE.
- IDLE:
  - On CMD_VALID&CMD_READY, latch op, effective address and data. Effective address is PTR for LDI/STI, CMD_ADR otherwise.
  - NOP: accepted, stays IDLE, no RES_VALID.
  - SETP: go to DONE. PTR<=CMD_ADR if CMD_ADR<DEPTH; otherwise PTR unchanged and RES_ERR=1.
  - Memory op with effective address >= DEPTH: go to DONE with RES_ERR=1, RES_DATA=0, no memory access.
  - Valid memory op: go to ACCESS.
- ACCESS:
  - MEM_EN=1, MEM_ADR=latched address.
  - ST/STI: MEM_WR=1, MEM_DI=latched data; go to DONE.
  - LD/LDI/INC/DEC: MEM_WR=0; capture MEM_DO at the edge. LD/LDI go to DONE; INC/DEC go to WBACK.
- WBACK:
  - MEM_EN=1, MEM_WR=1, MEM_ADR=latched address.
  - MEM_DI = captured ±1, modulo 2^DATA_W; the carry/borrow flag is registered here.
  - INC 0xF -> 0x0 with carry 1; DEC 0x0 -> 0xF with borrow 1.
  - Go to DONE.
- DONE:
  - RES_VALID=1 with RES_DATA/CARRY/ERR valid, then return to IDLE.
  - LDI/STI: PTR post-increments here, wrapping DEPTH-1 -> 0.
- Latency from accept edge t0: SETP/error ops RES_VALID in cycle t0+1; LD/ST t0+2; INC/DEC t0+3.
- Next command is accepted the cycle after DONE.
- MEM_ADR/MEM_DI hold 0 whenever MEM_EN=0.
- CMD_* inputs are ignored outside IDLE; the latched values are used throughout the command.

Decomposition:
- Shared package holds:
  - opcode constants OP_NOP..OP_STI;
  - state encoding;
  - DATA_W/ADDR_W/DEPTH defaults, shared with the memory block.
- One natural sub-module: mem_seq_ptr, the pointer register with load, wrap-increment and range check. Everything else stays in one FSM module.

Test Plan:
- Reset then ST adr 2 data 0xA, LD adr 2 -> MEM_WR pulses one cycle at adr 2; LD RES_VALID at t0+2 with RES_DATA=0xA, ERR=0.
- ST adr 4 0xF, INC adr 4 -> WBACK writes 0x0; RES_DATA=0x0, RES_CARRY=1 at t0+3; subsequent LD adr 4 returns 0x0.
- ST adr 0 0x0, DEC adr 0 -> RES_DATA=0xF, RES_CARRY=1.
- SETP 5, STI 0x3, STI 0x7 -> writes at adr 5 then adr 0 (PTR wraps 5->0->1); LD adr 5=0x3, LD adr 0=0x7.
- LD adr 6, SETP 7 -> RES_ERR=1 at t0+1, MEM_EN never asserted, PTR unchanged.
- Assert RST during WBACK of an INC -> memory location keeps its old value, no RES_VALID, CMD_READY=1 the cycle after RST drops, PTR=0.
